peak_task_sched: RTL and testbench
==================================

Name: peak_task_sched

Overview:
- Parametrised barrel-thread scheduler for the peak core family; generalises the fixed 8-task, 8-stage task-number ring into N tasks × S stages.
- Holds one PC and run state per hardware task and issues at most one fetch per cycle, round-robin over eligible tasks.
- Tracks each accepted fetch through an S-stage tag pipeline and takes the next PC back from writeback.
- Supports per-task halt/resume, enable masking and debug PC writes.

Parameters:
NUM_TASKS, 8, hardware task count; power of 2, range 2..16
STAGES, 8, tag pipeline depth; range 2..16
RESET_PC, 32'h0000_0000, PC loaded into every task at reset
TASK_W, $clog2(NUM_TASKS), derived; not overridable

Ports:
CLK  in  1  clock
RST  in  1  synchronous reset, active-high
TASK_EN  in  NUM_TASKS  per-task enable; 0 excludes task from issue
HALTREQ  in  NUM_TASKS  per-task halt request, level
RESUMEREQ  in  NUM_TASKS  per-task resume request, level
I_MEM_VALID  out  1  fetch request
I_MEM_ADDR  out  32  fetch address = PC of granted task
I_MEM_READY  in  1  fetch accepted this cycle
WB_VALID  in  1  task retire strobe
WB_TASK  in  TASK_W  retiring task
WB_NEXT_PC  in  32  next PC for retiring task
SET_PC_EN  in  1  debug PC write
SET_PC_TASK  in  TASK_W  debug target task
SET_PC_DATA  in  32  debug PC value
TAG_VALID  out  STAGES  per-stage valid; bit 0 = youngest
TAG_TASK  out  STAGES*TASK_W  per-stage task number, stage k at [k*TASK_W +: TASK_W]
TAG_PC  out  STAGES*32  per-stage PC, stage k at [k*32 +: 32]
HALT  out  NUM_TASKS  task halted
RUNNING  out  NUM_TASKS  TASK_EN & ~HALTED
WB_ERR  out  1  sticky; WB for a task not in flight

Behaviour:
- Per-task state: READY, INFLIGHT, HALTED. A task is eligible when READY, TASK_EN=1 and no halt is pending.
- Reset, one cycle, synchronous:
  - all PCs = RESET_PC; all tasks READY; halt-pending cleared
  - rr pointer = NUM_TASKS-1, so task 0 is granted first
  - TAG_VALID = 0; TAG_TASK = 0; TAG_PC = 0; HALT = 0; WB_ERR = 0; lock cleared
  - RST mid-operation discards all in-flight tags; late WB after reset sets WB_ERR.
- Grant:
  - Combinational round-robin search starting at rr_ptr+1 (mod NUM_TASKS).
  - I_MEM_VALID = any eligible task, or lock set. I_MEM_ADDR = PC of the granted task.
- Lock:
  - When I_MEM_VALID=1 and I_MEM_READY=0, the granted task is registered as locked.
  - While locked, I_MEM_VALID stays 1 and I_MEM_ADDR stays stable, regardless of TASK_EN, HALTREQ or other tasks.
- Accept (I_MEM_VALID & I_MEM_READY):
  - granted task → INFLIGHT; rr_ptr ← granted task; lock cleared
  - next cycle: TAG stage 0 = {1, task, pc}
- Tag pipeline: shifts every cycle with no stall (stage k+1 ← stage k). Stage STAGES-1 falls off the end.
- Retire (WB_VALID) for a task in INFLIGHT:
  - PC ← WB_NEXT_PC
  - state → HALTED if halt is pending, else READY; eligible again the next cycle
- Retire for a task not in INFLIGHT: ignored, and WB_ERR ← 1 until RST.
- HALTREQ[i]:
  - READY and not locked → HALTED next cycle.
  - INFLIGHT or locked → set halt-pending; HALTED at retire (INFLIGHT) or immediately after accept+retire (locked).
  - HALTED → no effect.
- RESUMEREQ[i]: HALTED → READY next cycle. If HALTREQ and RESUMEREQ are both asserted for the same task, halt wins.
- TASK_EN[i]=0: task is not granted; an in-flight task completes normally; PC is preserved.
- SET_PC:
  - Accepted only when the target is HALTED, or READY with TASK_EN=0; otherwise ignored.
  - Takes effect next cycle.
  - Cannot collide with WB, because the target is never INFLIGHT.
- Simultaneous WB and accept for the same task cannot occur, since the task must be READY to be granted. Simultaneous WB and accept for different tasks are both processed.
- HALT[i] = state==HALTED. All outputs are registered except I_MEM_VALID, I_MEM_ADDR and RUNNING.
- rr_ptr wraps NUM_TASKS-1 → 0. With one eligible task, it is re-granted every cycle it is READY.

Decomposition:
- Package peak_sched_pkg holds:
  - task state enum (READY/INFLIGHT/HALTED)
  - TASK_W helper function
  - RESET_PC default constant
- Sub-module peak_rr_arbiter, parametrised on NUM_TASKS: request mask + pointer → one-hot/binary grant and any-valid.
- Tag shift register and per-task state/PC arrays stay in the top module.

Test Plan:
- Basic rotation. RST, TASK_EN=8'hFF, I_MEM_READY=1, retire each task 8 cycles after issue with pc+4 → grants 0,1,2,…,7,0; I_MEM_ADDR sequence 0×8 then 4×8; TAG_TASK stage 7 lags stage 0 by 7 cycles.
- Stall lock. Hold I_MEM_READY=0 for 3 cycles while task 2 is granted, and assert HALTREQ[2] in stall cycle 1 → I_MEM_ADDR constant for 3 cycles; task 2 issues on READY; HALT[2]=1 the cycle after its WB.
- Sparse mask. TASK_EN=8'b1000_0100 → grants alternate 2,7,2,7 with no bubbles when WB returns in time. Tasks with TASK_EN=0 are never granted.
- Halt/resume race. Task 5 READY; HALTREQ[5]=RESUMEREQ[5]=1 for one cycle → HALT[5]=1. Then RESUMEREQ[5] alone → HALT[5]=0 next cycle and task 5 is re-granted.
- Debug PC write. Halt task 3, SET_PC task 3 = 32'h0000_1000, resume → next fetch for task 3 has I_MEM_ADDR=32'h1000. The same SET_PC sent while task 3 is INFLIGHT is ignored.
- Error and reset. WB_VALID for idle task 6 → WB_ERR=1 and stays sticky. Assert RST mid-run → next cycle all TAG_VALID=0, WB_ERR=0, and the first grant is task 0 at RESET_PC.

Source files
------------

// File: rtl/peak_sched_pkg.sv
// Shared types and helpers for the peak barrel-thread scheduler.
package peak_sched_pkg;

  typedef enum logic [1:0] {
    TS_READY    = 2'd0,
    TS_INFLIGHT = 2'd1,
    TS_HALTED   = 2'd2
  } task_st_e;

  localparam logic [31:0] PEAK_RESET_PC = 32'h0000_0000;

  function automatic int task_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/peak_rr_arbiter.sv
// Round-robin arbiter: first requester after ptr (mod NUM_TASKS) wins.
module peak_rr_arbiter
  import peak_sched_pkg::*;
#(
  parameter int NUM_TASKS = 8,
  localparam int TASK_W = task_w(NUM_TASKS)
) (
  input  logic [NUM_TASKS-1:0] req,
  input  logic [TASK_W-1:0]    ptr,
  output logic [NUM_TASKS-1:0] gnt_oh,
  output logic [TASK_W-1:0]    gnt_idx,
  output logic                 any
);

  logic [TASK_W-1:0] idx;

  // NUM_TASKS is a power of two, so the index add wraps for free.
  always_comb begin
    gnt_oh  = '0;
    gnt_idx = '0;
    any     = 1'b0;
    idx     = '0;
    for (int k = 1; k <= NUM_TASKS; k++) begin
      idx = ptr + TASK_W'(k);
      if (!any && req[idx]) begin
        any     = 1'b1;
        gnt_idx = idx;
      end
    end
    gnt_oh[gnt_idx] = any;
  end

endmodule

// File: rtl/peak_task_sched.sv
// Barrel-thread scheduler: per-task PC/run state, round-robin fetch issue,
// stall lock, and an S-stage tag pipeline tracking accepted fetches.
module peak_task_sched
  import peak_sched_pkg::*;
#(
  parameter int          NUM_TASKS = 8,
  parameter int          STAGES    = 8,
  parameter logic [31:0] RESET_PC  = PEAK_RESET_PC,
  localparam int         TASK_W    = task_w(NUM_TASKS)
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [NUM_TASKS-1:0]     TASK_EN,
  input  logic [NUM_TASKS-1:0]     HALTREQ,
  input  logic [NUM_TASKS-1:0]     RESUMEREQ,
  output logic                     I_MEM_VALID,
  output logic [31:0]              I_MEM_ADDR,
  input  logic                     I_MEM_READY,
  input  logic                     WB_VALID,
  input  logic [TASK_W-1:0]        WB_TASK,
  input  logic [31:0]              WB_NEXT_PC,
  input  logic                     SET_PC_EN,
  input  logic [TASK_W-1:0]        SET_PC_TASK,
  input  logic [31:0]              SET_PC_DATA,
  output logic [STAGES-1:0]        TAG_VALID,
  output logic [STAGES*TASK_W-1:0] TAG_TASK,
  output logic [STAGES*32-1:0]     TAG_PC,
  output logic [NUM_TASKS-1:0]     HALT,
  output logic [NUM_TASKS-1:0]     RUNNING,
  output logic                     WB_ERR
);

  logic [NUM_TASKS-1:0][31:0] pc_q;
  logic [NUM_TASKS-1:0]       elig, infl, arb_oh, sel_oh;
  logic [TASK_W-1:0]          rr_ptr, arb_idx, sel_idx, lock_task;
  logic                       lock_vld, arb_any, accept;

  logic [STAGES-1:0]             vld_pipe;
  logic [STAGES-1:0][TASK_W-1:0] task_pipe;
  logic [STAGES-1:0][31:0]       pc_pipe;

  peak_rr_arbiter #(.NUM_TASKS(NUM_TASKS)) u_arb (
    .req    (elig),
    .ptr    (rr_ptr),
    .gnt_oh (arb_oh),
    .gnt_idx(arb_idx),
    .any    (arb_any)
  );

  // A stalled grant is pinned so the fetch address cannot move under the memory.
  always_comb begin
    sel_oh  = arb_oh;
    sel_idx = arb_idx;
    if (lock_vld) begin
      sel_oh            = '0;
      sel_oh[lock_task] = 1'b1;
      sel_idx           = lock_task;
    end
  end

  assign I_MEM_VALID = lock_vld | arb_any;
  assign I_MEM_ADDR  = pc_q[sel_idx];
  assign accept      = I_MEM_VALID & I_MEM_READY;

  for (genvar i = 0; i < NUM_TASKS; i++) begin : g_task
    task_st_e    st;
    logic [31:0] pc_r;
    logic        hp, wb_hit, set_hit, gnt_hit;

    assign gnt_hit = I_MEM_VALID & sel_oh[i];
    assign wb_hit  = WB_VALID && (WB_TASK == TASK_W'(i));
    assign set_hit = SET_PC_EN && (SET_PC_TASK == TASK_W'(i)) && !sel_oh[i] &&
                     ((st == TS_HALTED) || ((st == TS_READY) && !TASK_EN[i]));

    // The current grant (accepting or stalled) defers a halt until it retires.
    always_ff @(posedge CLK) begin
      if (RST) begin
        st   <= TS_READY;
        pc_r <= RESET_PC;
        hp   <= 1'b0;
      end else begin
        if (gnt_hit) begin
          if (I_MEM_READY) st <= TS_INFLIGHT;
          if (HALTREQ[i])  hp <= 1'b1;
        end else begin
          case (st)
            TS_READY:    if (HALTREQ[i]) st <= TS_HALTED;
            TS_INFLIGHT: begin
              if (wb_hit) begin
                pc_r <= WB_NEXT_PC;
                st   <= (hp || HALTREQ[i]) ? TS_HALTED : TS_READY;
                hp   <= 1'b0;
              end else if (HALTREQ[i]) begin
                hp <= 1'b1;
              end
            end
            TS_HALTED:   if (RESUMEREQ[i] && !HALTREQ[i]) st <= TS_READY;
            default:     st <= TS_READY;
          endcase
        end
        if (set_hit) pc_r <= SET_PC_DATA;
      end
    end

    assign pc_q[i] = pc_r;
    assign elig[i] = (st == TS_READY) && TASK_EN[i] && !hp;
    assign infl[i] = (st == TS_INFLIGHT);
    assign HALT[i] = (st == TS_HALTED);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rr_ptr    <= TASK_W'(NUM_TASKS - 1);
      lock_vld  <= 1'b0;
      lock_task <= '0;
      vld_pipe  <= '0;
      task_pipe <= '0;
      pc_pipe   <= '0;
      WB_ERR    <= 1'b0;
    end else begin
      vld_pipe  <= {vld_pipe[STAGES-2:0], accept};
      task_pipe <= {task_pipe[STAGES-2:0], accept ? sel_idx : TASK_W'(0)};
      pc_pipe   <= {pc_pipe[STAGES-2:0], accept ? I_MEM_ADDR : 32'h0};
      if (accept) begin
        rr_ptr   <= sel_idx;
        lock_vld <= 1'b0;
      end else if (I_MEM_VALID) begin
        lock_vld  <= 1'b1;
        lock_task <= sel_idx;
      end
      if (WB_VALID && !infl[WB_TASK]) WB_ERR <= 1'b1;
    end
  end

  assign TAG_VALID = vld_pipe;
  assign TAG_TASK  = task_pipe;
  assign TAG_PC    = pc_pipe;
  assign RUNNING   = TASK_EN & ~HALT;

endmodule

// File: tb/tb_peak_task_sched.sv
// Scoreboard bench for peak_task_sched (8 tasks, 8 stages, RESET_PC = 0).
module tb_peak_task_sched;
  localparam int NT = 8;
  localparam int S  = 8;
  localparam int TW = 3;

  logic            CLK = 1'b0;
  logic            RST;
  logic [NT-1:0]   TASK_EN, HALTREQ, RESUMEREQ;
  logic            I_MEM_VALID, I_MEM_READY;
  logic [31:0]     I_MEM_ADDR;
  logic            WB_VALID;
  logic [TW-1:0]   WB_TASK;
  logic [31:0]     WB_NEXT_PC;
  logic            SET_PC_EN;
  logic [TW-1:0]   SET_PC_TASK;
  logic [31:0]     SET_PC_DATA;
  logic [S-1:0]    TAG_VALID;
  logic [S*TW-1:0] TAG_TASK;
  logic [S*32-1:0] TAG_PC;
  logic [NT-1:0]   HALT, RUNNING;
  logic            WB_ERR;

  peak_task_sched #(.NUM_TASKS(NT), .STAGES(S), .RESET_PC(32'h0)) dut (
    .CLK(CLK), .RST(RST), .TASK_EN(TASK_EN), .HALTREQ(HALTREQ), .RESUMEREQ(RESUMEREQ),
    .I_MEM_VALID(I_MEM_VALID), .I_MEM_ADDR(I_MEM_ADDR), .I_MEM_READY(I_MEM_READY),
    .WB_VALID(WB_VALID), .WB_TASK(WB_TASK), .WB_NEXT_PC(WB_NEXT_PC),
    .SET_PC_EN(SET_PC_EN), .SET_PC_TASK(SET_PC_TASK), .SET_PC_DATA(SET_PC_DATA),
    .TAG_VALID(TAG_VALID), .TAG_TASK(TAG_TASK), .TAG_PC(TAG_PC),
    .HALT(HALT), .RUNNING(RUNNING), .WB_ERR(WB_ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [TW-1:0] tk;
    logic [31:0]   pc;
  } exp_t;

  exp_t    sbq[$];
  exp_t    mon_e;
  int      n_cmp = 0;
  int      n_err = 0;
  bit      auto_wb = 1'b0;
  bit      man_wb_v = 1'b0;
  logic [TW-1:0] man_wb_t = '0;

  // Writeback responder: retire whatever reaches the last tag stage with pc+4.
  always_comb begin
    if (auto_wb) begin
      WB_VALID   = TAG_VALID[S-1];
      WB_TASK    = TAG_TASK[(S-1)*TW +: TW];
      WB_NEXT_PC = TAG_PC[(S-1)*32 +: 32] + 32'd4;
    end else begin
      WB_VALID   = man_wb_v;
      WB_TASK    = man_wb_t;
      WB_NEXT_PC = 32'h0;
    end
  end

  always @(negedge CLK) begin
    if (TAG_VALID[0] && sbq.size() > 0) begin
      mon_e = sbq.pop_front();
      n_cmp++;
      if (TAG_TASK[TW-1:0] !== mon_e.tk || TAG_PC[31:0] !== mon_e.pc) begin
        n_err++;
        $display("FAIL sb_issue: got task %0d pc %h, want task %0d pc %h",
                 TAG_TASK[TW-1:0], TAG_PC[31:0], mon_e.tk, mon_e.pc);
      end
    end
  end

  task automatic push(input int t, input logic [31:0] p);
    exp_t e;
    e.tk = TW'(t);
    e.pc = p;
    sbq.push_back(e);
  endtask

  task automatic drain(input int budget, output bit ok);
    for (int i = 0; i < budget; i++) begin
      if (sbq.size() == 0) break;
      @(negedge CLK);
    end
    ok = (sbq.size() == 0);
  endtask

  task automatic do_reset();
    RST = 1'b1; TASK_EN = '0; HALTREQ = '0; RESUMEREQ = '0; I_MEM_READY = 1'b1;
    SET_PC_EN = 1'b0; SET_PC_TASK = '0; SET_PC_DATA = '0; man_wb_v = 1'b0;
    sbq.delete();
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (TAG_VALID !== '0 || TAG_TASK !== '0 || TAG_PC !== '0) begin n_err++;
      $display("FAIL reset_tags: got %h/%h, want 0", TAG_VALID, TAG_TASK); end
    n_cmp++; if (HALT !== '0 || RUNNING !== '0 || WB_ERR !== 1'b0) begin n_err++;
      $display("FAIL reset_status: halt %h run %h err %b, want 0", HALT, RUNNING, WB_ERR); end
    n_cmp++; if (I_MEM_VALID !== 1'b0) begin n_err++;
      $display("FAIL reset_idle: valid %b, want 0", I_MEM_VALID); end
    TASK_EN = 8'hFF;
    #1;
    n_cmp++; if (I_MEM_VALID !== 1'b1 || I_MEM_ADDR !== 32'h0 || RUNNING !== 8'hFF) begin n_err++;
      $display("FAIL reset_first_req: valid %b addr %h run %h, want 1 0 ff", I_MEM_VALID, I_MEM_ADDR, RUNNING); end
  endtask

  task automatic test_rotation();
    int e;
    bit ok;
    do_reset();
    auto_wb = 1'b1;
    for (int t = 0; t < NT; t++) push(t, 32'h0);
    for (int t = 0; t < NT; t++) push(t, 32'h4);
    TASK_EN = 8'hFF;
    for (int c = 0; c < 24; c++) begin
      @(negedge CLK);
      e = -1;
      if (c >= 7 && c <= 14) e = c - 7;
      else if (c >= 16 && c <= 23) e = c - 16;
      n_cmp++;
      if (TAG_VALID[S-1] !== (e >= 0) || (e >= 0 && TAG_TASK[(S-1)*TW +: TW] !== TW'(e))) begin
        n_err++;
        $display("FAIL rot_stage7 c=%0d: got v%b task %0d, want task %0d", c, TAG_VALID[S-1],
                 TAG_TASK[(S-1)*TW +: TW], e);
      end
    end
    drain(4, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL rot_drain: %0d issues missing, want 0", sbq.size()); end
    TASK_EN = '0;
  endtask

  task automatic test_stall_lock();
    bit ok, seen;
    do_reset();
    auto_wb = 1'b1;
    for (int t = 0; t < NT; t++) begin
      SET_PC_EN = 1'b1; SET_PC_TASK = TW'(t); SET_PC_DATA = 32'(t * 256);
      @(negedge CLK);
    end
    SET_PC_EN = 1'b0;
    push(0, 32'h000); push(1, 32'h100); push(2, 32'h200); push(3, 32'h300);
    TASK_EN = 8'hFF;
    repeat (2) @(negedge CLK);
    I_MEM_READY = 1'b0; HALTREQ = 8'h04;
    #1;
    n_cmp++; if (I_MEM_VALID !== 1'b1 || I_MEM_ADDR !== 32'h200) begin n_err++;
      $display("FAIL stall_c1: valid %b addr %h, want 1 200", I_MEM_VALID, I_MEM_ADDR); end
    @(negedge CLK);
    HALTREQ = '0; TASK_EN = 8'hFB;
    #1;
    n_cmp++; if (I_MEM_VALID !== 1'b1 || I_MEM_ADDR !== 32'h200 || HALT[2] !== 1'b0) begin n_err++;
      $display("FAIL stall_c2: valid %b addr %h halt %b, want 1 200 0", I_MEM_VALID, I_MEM_ADDR, HALT[2]); end
    @(negedge CLK);
    #1;
    n_cmp++; if (I_MEM_ADDR !== 32'h200) begin n_err++;
      $display("FAIL stall_c3: addr %h, want 200", I_MEM_ADDR); end
    @(negedge CLK);
    TASK_EN = 8'hFF; I_MEM_READY = 1'b1;
    #1;
    n_cmp++; if (I_MEM_VALID !== 1'b1 || I_MEM_ADDR !== 32'h200) begin n_err++;
      $display("FAIL stall_release: valid %b addr %h, want 1 200", I_MEM_VALID, I_MEM_ADDR); end
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge CLK);
      if (WB_VALID && WB_TASK == 3'd2) seen = 1'b1;
    end
    n_cmp++; if (!seen || HALT[2] !== 1'b0 || TAG_PC[(S-1)*32 +: 32] !== 32'h200) begin n_err++;
      $display("FAIL stall_wb2: seen %b halt %b pc %h, want 1 0 200", seen, HALT[2], TAG_PC[(S-1)*32 +: 32]); end
    @(negedge CLK);
    n_cmp++; if (HALT[2] !== 1'b1 || RUNNING[2] !== 1'b0) begin n_err++;
      $display("FAIL stall_halted: halt %b run %b, want 1 0", HALT[2], RUNNING[2]); end
    drain(4, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL stall_drain: %0d issues missing, want 0", sbq.size()); end
    TASK_EN = '0;
  endtask

  task automatic test_sparse_mask();
    bit ok;
    do_reset();
    auto_wb = 1'b1;
    push(2, 32'h0); push(7, 32'h0); push(2, 32'h4); push(7, 32'h4); push(2, 32'h8); push(7, 32'h8);
    TASK_EN = 8'b1000_0100;
    for (int c = 0; c < 40; c++) begin
      @(negedge CLK);
      if (TAG_VALID[0]) begin
        n_cmp++;
        if (TAG_TASK[TW-1:0] !== 3'd2 && TAG_TASK[TW-1:0] !== 3'd7) begin n_err++;
          $display("FAIL sparse_masked: got task %0d, want 2 or 7", TAG_TASK[TW-1:0]); end
      end
    end
    drain(2, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL sparse_drain: %0d issues missing, want 0", sbq.size()); end
    TASK_EN = '0;
  endtask

  task automatic test_halt_race();
    bit ok;
    do_reset();
    auto_wb = 1'b0;
    HALTREQ = 8'h20; RESUMEREQ = 8'h20;
    @(negedge CLK);
    HALTREQ = '0; RESUMEREQ = '0;
    n_cmp++; if (HALT !== 8'h20) begin n_err++;
      $display("FAIL race_halt: halt %h, want 20", HALT); end
    TASK_EN = 8'h20;
    #1;
    n_cmp++; if (I_MEM_VALID !== 1'b0 || RUNNING !== 8'h00) begin n_err++;
      $display("FAIL race_no_issue: valid %b run %h, want 0 00", I_MEM_VALID, RUNNING); end
    push(5, 32'h0);
    RESUMEREQ = 8'h20;
    @(negedge CLK);
    RESUMEREQ = '0;
    #1;
    n_cmp++; if (HALT[5] !== 1'b0 || I_MEM_VALID !== 1'b1 || I_MEM_ADDR !== 32'h0) begin n_err++;
      $display("FAIL race_resume: halt %b valid %b addr %h, want 0 1 0", HALT[5], I_MEM_VALID, I_MEM_ADDR); end
    drain(10, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL race_drain: %0d issues missing, want 0", sbq.size()); end
    TASK_EN = '0;
  endtask

  task automatic test_debug_pc();
    bit ok, seen;
    do_reset();
    auto_wb = 1'b1;
    HALTREQ = 8'h08;
    @(negedge CLK);
    HALTREQ = '0;
    SET_PC_EN = 1'b1; SET_PC_TASK = 3'd3; SET_PC_DATA = 32'h0000_1000;
    @(negedge CLK);
    SET_PC_EN = 1'b0;
    n_cmp++; if (HALT !== 8'h08) begin n_err++; $display("FAIL dbg_halted: halt %h, want 08", HALT); end
    push(3, 32'h1000); push(3, 32'h1004);
    RESUMEREQ = 8'h08; TASK_EN = 8'h08;
    @(negedge CLK);
    RESUMEREQ = '0;
    #1;
    n_cmp++; if (I_MEM_VALID !== 1'b1 || I_MEM_ADDR !== 32'h1000) begin n_err++;
      $display("FAIL dbg_fetch: valid %b addr %h, want 1 1000", I_MEM_VALID, I_MEM_ADDR); end
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge CLK);
      seen = TAG_VALID[0];
    end
    n_cmp++; if (!seen) begin n_err++; $display("FAIL dbg_issue_wait: no issue seen, want one"); end
    SET_PC_EN = 1'b1; SET_PC_TASK = 3'd3; SET_PC_DATA = 32'hDEAD_0000;
    @(negedge CLK);
    SET_PC_EN = 1'b0;
    drain(20, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL dbg_drain: %0d issues missing, want 0", sbq.size()); end
    TASK_EN = '0;
  endtask

  task automatic test_err_reset();
    bit ok;
    do_reset();
    auto_wb = 1'b0;
    man_wb_v = 1'b1; man_wb_t = 3'd6;
    @(negedge CLK);
    man_wb_v = 1'b0;
    n_cmp++; if (WB_ERR !== 1'b1) begin n_err++; $display("FAIL err_set: got %b, want 1", WB_ERR); end
    repeat (3) @(negedge CLK);
    n_cmp++; if (WB_ERR !== 1'b1) begin n_err++; $display("FAIL err_sticky: got %b, want 1", WB_ERR); end
    auto_wb = 1'b1; TASK_EN = 8'hFF;
    repeat (5) @(negedge CLK);
    RST = 1'b1; TASK_EN = 8'h01;
    @(negedge CLK);
    RST = 1'b0;
    n_cmp++; if (TAG_VALID !== '0 || WB_ERR !== 1'b0 || HALT !== '0) begin n_err++;
      $display("FAIL rst_mid: tags %h err %b halt %h, want 0 0 0", TAG_VALID, WB_ERR, HALT); end
    n_cmp++; if (I_MEM_VALID !== 1'b1 || I_MEM_ADDR !== 32'h0) begin n_err++;
      $display("FAIL rst_first: valid %b addr %h, want 1 0", I_MEM_VALID, I_MEM_ADDR); end
    push(0, 32'h0);
    drain(4, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL rst_drain: %0d issues missing, want 0", sbq.size()); end
    auto_wb = 1'b0; TASK_EN = '0;
    man_wb_v = 1'b1; man_wb_t = 3'd2;
    @(negedge CLK);
    man_wb_v = 1'b0;
    n_cmp++; if (WB_ERR !== 1'b1) begin n_err++; $display("FAIL err_late_wb: got %b, want 1", WB_ERR); end
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_stall_lock();
    test_sparse_mask();
    test_halt_race();
    test_debug_pc();
    test_err_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
